// File: rtl/rr_arbiter_hold.sv
// Round-robin arbiter that locks a grant for a whole transfer, releasing on
// end-of-transfer, request drop or hold timeout, with one GAP cycle between owners.
module rr_arbiter_hold #(
  parameter int NUM_REQ  = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 256,
  parameter int CNT_W    = 9
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               qArbitEnable,
  input  logic [NUM_REQ-1:0] qvRequest,
  input  logic [NUM_REQ-1:0] qvRelease,
  output logic [NUM_REQ-1:0] qvGrant,
  output logic               qGrantValid,
  output logic [IDX_W-1:0]   qvGrantIndex,
  output logic               qHoldTimeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [CNT_W-1:0]   CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit                 TMO_EN   = (MAX_HOLD != 0);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]   IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]     N_EXT    = (IDX_W+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_ptr;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_REQ-1:0]   r_grant;
  logic                 r_valid;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_tmo;

  logic [2*NUM_REQ-1:0] w_rot;
  logic                 w_found;
  logic [IDX_W:0]       w_sum;
  logic [IDX_W-1:0]     w_win;
  logic                 w_own_rel;
  logic                 w_own_req;
  logic                 w_tmo;
  logic [IDX_W-1:0]     w_next_ptr;

  // Rotate requests so bit k is requester (ptr+k) mod NUM_REQ, then take the lowest set bit.
  always_comb begin
    w_rot   = {qvRequest, qvRequest} >> r_ptr;
    w_found = 1'b0;
    w_sum   = {(IDX_W+1){1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IDX_W+1)'(k);
      end else begin
        w_found = w_found;
      end
    end
    if (w_sum >= N_EXT) begin
      w_win = IDX_W'(w_sum - N_EXT);
    end else begin
      w_win = w_sum[IDX_W-1:0];
    end
  end

  assign w_own_rel  = |(qvRelease & r_grant);
  assign w_own_req  = |(qvRequest & r_grant);
  assign w_tmo      = TMO_EN && (r_cnt == HOLD_LIM);
  assign w_next_ptr = (r_idx == LAST_IDX) ? {IDX_W{1'b0}} : (r_idx + IDX_ONE);

  // FSM: IDLE arbitrates, HOLD keeps the grant locked, GAP forces one clean grant-low cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= {IDX_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_grant <= {NUM_REQ{1'b0}};
      r_valid <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
      r_tmo   <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (qArbitEnable && w_found) begin
            r_grant <= ONE_HOT0 << w_win;
            r_valid <= 1'b1;
            r_idx   <= w_win;
            r_cnt   <= CNT_ONE;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (w_own_rel || !w_own_req || w_tmo) begin
            r_grant <= {NUM_REQ{1'b0}};
            r_valid <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_cnt   <= {CNT_W{1'b0}};
            // A coinciding release or request drop counts as a normal end of transfer.
            r_tmo   <= w_tmo && !w_own_rel && w_own_req;
            r_state <= S_GAP;
          end else if (r_cnt != CNT_SAT) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= {NUM_REQ{1'b0}};
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign qvGrant      = r_grant;
  assign qGrantValid  = r_valid;
  assign qvGrantIndex = r_idx;
  assign qHoldTimeout = r_tmo;

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Directed bench for rr_arbiter_hold: an 8-requester instance with a short hold
// limit, and a 5-requester instance for non-power-of-two pointer wrap.
module tb_rr_arbiter_hold;

  logic       clock;
  logic       reset;

  logic       a_en;
  logic [7:0] a_req, a_rel, a_grant;
  logic       a_valid, a_tmo;
  logic [2:0] a_idx;

  logic       b_en;
  logic [4:0] b_req, b_rel, b_grant;
  logic       b_valid, b_tmo;
  logic [2:0] b_idx;

  int n_tests = 0;
  int n_fail  = 0;

  rr_arbiter_hold #(.NUM_REQ(8), .IDX_W(3), .MAX_HOLD(4), .CNT_W(3)) u_dut_a (
    .clock(clock), .reset(reset), .qArbitEnable(a_en),
    .qvRequest(a_req), .qvRelease(a_rel), .qvGrant(a_grant),
    .qGrantValid(a_valid), .qvGrantIndex(a_idx), .qHoldTimeout(a_tmo)
  );

  rr_arbiter_hold #(.NUM_REQ(5), .IDX_W(3), .MAX_HOLD(4), .CNT_W(3)) u_dut_b (
    .clock(clock), .reset(reset), .qArbitEnable(b_en),
    .qvRequest(b_req), .qvRelease(b_rel), .qvGrant(b_grant),
    .qGrantValid(b_valid), .qvGrantIndex(b_idx), .qHoldTimeout(b_tmo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] i, input logic t);
    chk({tag, ".grant"}, {24'd0, a_grant}, {24'd0, g});
    chk({tag, ".valid"}, {31'd0, a_valid}, {31'd0, (g != 8'h00)});
    chk({tag, ".index"}, {29'd0, a_idx}, {29'd0, i});
    chk({tag, ".tmo"},   {31'd0, a_tmo}, {31'd0, t});
  endtask

  initial begin
    reset = 1'b1;
    a_en = 1'b0; a_req = 8'h00; a_rel = 8'h00;
    b_en = 1'b0; b_req = 5'h00; b_rel = 5'h00;
    repeat (3) cyc();
    chk_a("reset_a", 8'h00, 3'd0, 1'b0);
    chk("reset_b.grant", {27'd0, b_grant}, 32'd0);
    reset = 1'b0;

    // N=5: requesters 4 and 0, immediate release; grants 0,4,0,4 every third cycle
    b_en = 1'b1; b_req = 5'b10001; b_rel = 5'b10001;
    for (int g = 0; g < 4; g++) begin
      cyc();
      chk("b_rr.grant", {27'd0, b_grant}, (g % 2 == 0) ? 32'h01 : 32'h10);
      chk("b_rr.index", {29'd0, b_idx},   (g % 2 == 0) ? 32'd0  : 32'd4);
      cyc();
      chk("b_rr.gap",   {27'd0, b_grant}, 32'd0);
      cyc();
      chk("b_rr.idle",  {27'd0, b_grant}, 32'd0);
    end
    b_req = 5'h00; b_rel = 5'h00;

    // N=8 all requesting, 2-cycle holds: 0..7 then 0
    a_en = 1'b1; a_req = 8'hFF;
    for (int n = 0; n < 9; n++) begin
      cyc();
      chk_a("rr.grant1", 8'h01 << (n % 8), 3'(n % 8), 1'b0);
      cyc();
      chk_a("rr.grant2", 8'h01 << (n % 8), 3'(n % 8), 1'b0);
      a_rel = 8'h01 << (n % 8);
      cyc();
      a_rel = 8'h00;
      chk_a("rr.gap", 8'h00, 3'(n % 8), 1'b0);
      if (n == 8) a_req = 8'h00;
      cyc();
      chk_a("rr.idle", 8'h00, 3'(n % 8), 1'b0);
    end

    // Timeout: requester 2 alone holds 4 cycles; pointer now 1
    a_req = 8'h04;
    cyc();
    chk_a("tmo.g1", 8'h04, 3'd2, 1'b0);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk_a("tmo.hold", 8'h04, 3'd2, 1'b0);
    end
    a_req = 8'h26;
    cyc();
    chk_a("tmo.pulse", 8'h00, 3'd2, 1'b1);
    cyc();
    chk_a("tmo.after", 8'h00, 3'd2, 1'b0);
    cyc();
    chk_a("tmo.next", 8'h20, 3'd5, 1'b0);
    a_rel = 8'h20;
    cyc();
    a_rel = 8'h00; a_req = 8'h00;
    chk_a("tmo.rel5", 8'h00, 3'd5, 1'b0);
    cyc();

    // Release coinciding with the hold limit is a normal release; pointer 6 -> winner 1
    a_req = 8'h02;
    cyc();
    chk_a("coin.g", 8'h02, 3'd1, 1'b0);
    repeat (3) cyc();
    chk_a("coin.cnt4", 8'h02, 3'd1, 1'b0);
    a_rel = 8'h02;
    cyc();
    a_rel = 8'h00;
    chk_a("coin.end", 8'h00, 3'd1, 1'b0);
    a_req = 8'h00;
    cyc();

    // Owner 3 drops request; non-owner release on bit 5 is ignored
    a_req = 8'h08;
    cyc();
    chk_a("drop.g", 8'h08, 3'd3, 1'b0);
    a_rel = 8'h20;
    cyc();
    chk_a("drop.nonown", 8'h08, 3'd3, 1'b0);
    a_req = 8'h00;
    cyc();
    a_rel = 8'h00;
    chk_a("drop.end", 8'h00, 3'd3, 1'b0);

    // Enable gating; pointer 4 with requests 1 and 6 -> winner 6
    a_en = 1'b0; a_req = 8'h42;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk_a("en.off", 8'h00, 3'd3, 1'b0);
    end
    a_en = 1'b1;
    cyc();
    chk_a("en.on", 8'h40, 3'd6, 1'b0);
    a_en = 1'b0;
    cyc();
    chk_a("en.drop1", 8'h40, 3'd6, 1'b0);
    cyc();
    chk_a("en.drop2", 8'h40, 3'd6, 1'b0);
    a_rel = 8'h40;
    cyc();
    a_rel = 8'h00;
    chk_a("en.rel", 8'h00, 3'd6, 1'b0);
    cyc();
    cyc();
    chk_a("en.idle_off", 8'h00, 3'd6, 1'b0);

    // Reset mid-hold; requester 7 added so a stale pointer of 7 would be visible
    a_en = 1'b1; a_req = 8'h10;
    cyc();
    chk_a("rst.g4", 8'h10, 3'd4, 1'b0);
    a_req = 8'h91; reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_a("rst.clear", 8'h00, 3'd0, 1'b0);
    cyc();
    chk_a("rst.first", 8'h01, 3'd0, 1'b0);
    a_rel = 8'h01; a_req = 8'h00;
    cyc();
    a_rel = 8'h00;
    chk_a("rst.end", 8'h00, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
